// File: rtl/router_pkg.sv
// -----------------------------------------------------------------------------
// router_pkg
// Shared constants for the collective router datapath.
//   FLIT_SIZE / PORT_NUM  : flit width and number of router output ports
//   port_e                : output port indices (bit i of a port mask = port i)
//   FLIT_*_LSB / FLIT_*_W : flit field layout, used where the destination mask
//                           is decoded upstream of the multicast tree
//   port_bit()            : one-hot mask for a single port
// -----------------------------------------------------------------------------
package router_pkg;

  localparam int FLIT_SIZE = 82;
  localparam int PORT_NUM  = 6;

  // Output port indices, one per mesh direction.
  typedef enum logic [2:0] {
    PORT_XP = 3'd0,
    PORT_XM = 3'd1,
    PORT_YP = 3'd2,
    PORT_YM = 3'd3,
    PORT_ZP = 3'd4,
    PORT_ZM = 3'd5
  } port_e;

  // Flit field layout: [81:80] type, [79:64] destination/collective id, [63:0] payload.
  localparam int FLIT_DATA_LSB = 0;
  localparam int FLIT_DATA_W   = 64;
  localparam int FLIT_DEST_LSB = 64;
  localparam int FLIT_DEST_W   = 16;
  localparam int FLIT_TYPE_LSB = 80;
  localparam int FLIT_TYPE_W   = 2;

  // One-hot port mask for a single output port.
  function automatic logic [PORT_NUM-1:0] port_bit(input port_e p);
    return {{(PORT_NUM-1){1'b0}}, 1'b1} << p;
  endfunction

endpackage

// File: rtl/multicast_tree.sv
// -----------------------------------------------------------------------------
// multicast_tree
// Replicates one flit from the router core onto every output port named in a
// destination mask, and holds it until each targeted port has taken its copy.
// Single flit register plus a pending-port mask; the IDLE/SEND state is simply
// (pend_q == 0) / (pend_q != 0), so there is no separate state register.
//
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous reset, active low
//   in         in   incoming flit (FLIT_SIZE)
//   in_valid   in   incoming flit valid
//   in_mask    in   destination ports, bit i targets port i (FAN_OUT)
//   in_avail   out  a flit can be accepted this cycle
//   out        out  per-port flit copies, port i at [i*FLIT_SIZE +: FLIT_SIZE]
//   out_valid  out  per-port valid (FAN_OUT)
//   out_avail  in   per-port downstream ready (FAN_OUT)
//   drop_cnt   out  saturating count of accepted zero-mask flits (16 bits),
//                   present only when MCAST_DROP_CNT_EN is defined
//
// Build option: MCAST_DROP_CNT_EN adds the drop_cnt port and counter; without
// it, zero-mask flits are discarded silently.
// -----------------------------------------------------------------------------
module multicast_tree #(
  parameter int FAN_OUT   = router_pkg::PORT_NUM,
  parameter int FLIT_SIZE = router_pkg::FLIT_SIZE
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [FLIT_SIZE-1:0]         in,
  input  logic                         in_valid,
  input  logic [FAN_OUT-1:0]           in_mask,
  output logic                         in_avail,
  output logic [FLIT_SIZE*FAN_OUT-1:0] out,
  output logic [FAN_OUT-1:0]           out_valid,
  input  logic [FAN_OUT-1:0]           out_avail
`ifdef MCAST_DROP_CNT_EN
  ,
  output logic [15:0]                  drop_cnt
`endif
);

  logic [FLIT_SIZE-1:0] flit_q;
  logic [FAN_OUT-1:0]   pend_q;
  logic [FAN_OUT-1:0]   rem_s;
  logic                 accept_s;

  // Per-port clear: a port stays pending only while it is still waiting for
  // downstream ready; every slice carries the held flit, qualified by out_valid.
  for (genvar g = 0; g < FAN_OUT; g++) begin : g_port
    assign rem_s[g]                          = pend_q[g] & ~out_avail[g];
    assign out[g*FLIT_SIZE +: FLIT_SIZE]     = flit_q;
  end

  assign out_valid = pend_q;

  // A new flit may enter on the same cycle the last pending ports drain, which
  // keeps back-to-back throughput at one flit per cycle.
  assign in_avail = (rem_s == {FAN_OUT{1'b0}});
  assign accept_s = in_valid & in_avail;

  // Flit and pending-mask registers; reset discards any partially sent flit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      flit_q <= {FLIT_SIZE{1'b0}};
      pend_q <= {FAN_OUT{1'b0}};
    end else if (accept_s) begin
      flit_q <= in;
      pend_q <= in_mask;
    end else begin
      flit_q <= flit_q;
      pend_q <= rem_s;
    end
  end

`ifdef MCAST_DROP_CNT_EN
  logic [15:0] drop_cnt_q;

  // Saturating count of accepted flits that targeted no port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt_q <= 16'h0000;
    end else if (accept_s && (in_mask == {FAN_OUT{1'b0}}) && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'h0001;
    end else begin
      drop_cnt_q <= drop_cnt_q;
    end
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_multicast_tree.sv
// -----------------------------------------------------------------------------
// tb_multicast_tree
// Scoreboard bench for multicast_tree: each accepted flit pushes one expected
// copy per targeted port; each port transfer pops and compares. A small
// reference of the pending mask tracks out_valid / in_avail cycle by cycle.
// -----------------------------------------------------------------------------
module tb_multicast_tree;

  localparam int FO = 6;
  localparam int FW = 82;

  typedef logic [FW-1:0] flit_t;

  logic                clk;
  logic                rst;
  logic [FW-1:0]       din;
  logic                din_valid;
  logic [FO-1:0]       din_mask;
  logic                din_avail;
  logic [FW*FO-1:0]    dout;
  logic [FO-1:0]       dout_valid;
  logic [FO-1:0]       dout_avail;
`ifdef MCAST_DROP_CNT_EN
  logic [15:0]         drop_cnt;
`endif

  multicast_tree #(.FAN_OUT(FO), .FLIT_SIZE(FW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (din),
    .in_valid  (din_valid),
    .in_mask   (din_mask),
    .in_avail  (din_avail),
    .out       (dout),
    .out_valid (dout_valid),
    .out_avail (dout_avail)
`ifdef MCAST_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state.
  flit_t         m_flit;
  logic [FO-1:0] m_pend;
  logic [15:0]   m_drop;
  flit_t         exp_q [FO][$];

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_flit = '0;
    m_pend = '0;
    m_drop = 16'h0000;
    for (int i = 0; i < FO; i++) exp_q[i].delete();
  endtask

  // One clock cycle: drive inputs, check at the falling edge, update the model.
  task automatic cycle(input flit_t d, input logic v, input logic [FO-1:0] m,
                       input logic [FO-1:0] oa, output logic acc);
    logic exp_avail;
    din = d; din_valid = v; din_mask = m; dout_avail = oa;
    @(negedge clk);
    exp_avail = ((m_pend & ~oa) == '0);
    check_val("out_valid", dout_valid, m_pend);
    check_val("in_avail", din_avail, exp_avail);
    for (int i = 0; i < FO; i++) begin
      check_val("out_slice", dout[i*FW +: FW], m_flit);
      if (dout_valid[i] && oa[i]) begin
        if (exp_q[i].size() == 0) begin
          check_val("unexpected_xfer", {122'd0, i[5:0]}, 128'hFFFF);
        end else begin
          check_val("xfer_flit", dout[i*FW +: FW], exp_q[i].pop_front());
        end
      end
    end
`ifdef MCAST_DROP_CNT_EN
    check_val("drop_cnt", drop_cnt, m_drop);
`endif
    acc = v && exp_avail;
    if (acc) begin
      for (int i = 0; i < FO; i++) if (m[i]) exp_q[i].push_back(d);
      m_flit = d;
      m_pend = m;
      if (m == '0 && m_drop != 16'hFFFF) m_drop = m_drop + 16'h0001;
    end else begin
      m_pend = m_pend & ~oa;
    end
    @(posedge clk);
    #1;
  endtask

  logic          acc;
  flit_t         held_flit;
  logic [FO-1:0] held_mask;
  logic          held_v;

  initial begin
    rst = 1'b0; din = '0; din_valid = 1'b0; din_mask = '0; dout_avail = '0;
    model_reset();
    #12;
    check_val("rst_out_valid", dout_valid, 6'b000000);
    check_val("rst_in_avail", din_avail, 1'b1);
    check_val("rst_out", dout, {(FW*FO){1'b0}});
    @(posedge clk); #1;
    rst = 1'b1;

    // 1: single port delivery
    cycle(82'h1234, 1'b1, 6'b000001, 6'b111111, acc);
    check_val("t1_accept", acc, 1'b1);
    cycle('0, 1'b0, 6'b000000, 6'b111111, acc);
    check_val("t1_port0", dout[0 +: FW], 82'h1234);
    cycle('0, 1'b0, 6'b000000, 6'b111111, acc);

    // 2: broadcast with partial ready
    cycle(82'h2_ABCD_0000_5555_AAAA, 1'b1, 6'b111111, 6'b000000, acc);
    cycle('0, 1'b0, 6'b000000, 6'b000101, acc);
    cycle('0, 1'b0, 6'b000000, 6'b111010, acc);
    cycle('0, 1'b0, 6'b000000, 6'b111111, acc);

    // 3: back-to-back, no bubble
    cycle(82'hA, 1'b1, 6'b000011, 6'b111111, acc);
    check_val("t3_accA", acc, 1'b1);
    cycle(82'hB, 1'b1, 6'b000110, 6'b111111, acc);
    check_val("t3_accB", acc, 1'b1);
    cycle('0, 1'b0, 6'b000000, 6'b111111, acc);
    cycle('0, 1'b0, 6'b000000, 6'b111111, acc);

    // 5: stall on port 5 with a held follower
    cycle(82'h3_0000_0000_0000_0055, 1'b1, 6'b100000, 6'b000000, acc);
    for (int k = 0; k < 10; k++) begin
      cycle(82'h77, 1'b1, 6'b000100, 6'b000000, acc);
      check_val("t5_hold", acc, 1'b0);
      check_val("t5_slice5", dout[5*FW +: FW], 82'h3_0000_0000_0000_0055);
    end
    cycle(82'h77, 1'b1, 6'b000100, 6'b100000, acc);
    check_val("t5_release_acc", acc, 1'b1);
    cycle('0, 1'b0, 6'b000000, 6'b111111, acc);
    cycle('0, 1'b0, 6'b000000, 6'b111111, acc);

    // randomized traffic, upstream holds each flit until accepted
    held_v = 1'b0; held_flit = '0; held_mask = '0;
    for (int k = 0; k < 60; k++) begin
      if (!held_v) begin
        held_v    = ($urandom_range(0, 3) != 0);
        held_flit = {18'($urandom), 32'($urandom), 32'($urandom)};
        held_mask = FO'($urandom);
      end
      cycle(held_flit, held_v, held_mask, FO'($urandom), acc);
      if (acc) held_v = 1'b0;
    end
    for (int k = 0; k < 3; k++) cycle('0, 1'b0, 6'b000000, 6'b111111, acc);

    // 6: asynchronous reset mid-send
    cycle(82'h6_6666, 1'b1, 6'b011000, 6'b000000, acc);
    check_val("t6_pend", dout_valid, 6'b011000);
    #2;
    rst = 1'b0;
    #1;
    check_val("t6_async_valid", dout_valid, 6'b000000);
    check_val("t6_async_out", dout, {(FW*FO){1'b0}});
    check_val("t6_async_avail", din_avail, 1'b1);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    for (int k = 0; k < 3; k++) cycle('0, 1'b0, 6'b000000, 6'b111111, acc);

    // 4: zero-mask drops
    for (int k = 0; k < 3; k++) cycle(82'hDEAD, 1'b1, 6'b000000, 6'b111111, acc);
    cycle('0, 1'b0, 6'b000000, 6'b111111, acc);
`ifdef MCAST_DROP_CNT_EN
    check_val("t4_drop3", drop_cnt, 16'd3);
    while (m_drop != 16'hFFFF) cycle(82'hDEAD, 1'b1, 6'b000000, 6'b111111, acc);
    cycle(82'hDEAD, 1'b1, 6'b000000, 6'b111111, acc);
    cycle(82'hDEAD, 1'b1, 6'b000000, 6'b111111, acc);
    cycle('0, 1'b0, 6'b000000, 6'b111111, acc);
    check_val("t4_drop_sat", drop_cnt, 16'hFFFF);
`endif

    // every expected copy delivered exactly once
    for (int i = 0; i < FO; i++) check_val("q_empty", exp_q[i].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
